// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module   : seq_alu_pkg
// Desc     : Shared op encodings, FSM state type and width helper for seq_alu.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_mul_core.sv
// ============================================================================
// Module   : seq_alu_mul_core
// Desc     : Iterative shift-add unsigned multiplier, one partial product/cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu_mul_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CW     = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_a_shift;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_b_shift;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_product_next;

    assign w_product_next = r_b_shift[0] ? (r_product + r_a_shift) : r_product;

    // done and product are presented in the final iteration's cycle so the
    // consumer can register the finished product on the same edge.
    assign done    = r_busy && (r_count == C_LAST);
    assign product = w_product_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_shift <= '0;
            r_b_shift <= '0;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else if (start) begin
            r_a_shift <= {{WIDTH{1'b0}}, a};
            r_b_shift <= b;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_product <= w_product_next;
            r_a_shift <= r_a_shift << 1;
            r_b_shift <= r_b_shift >> 1;
            r_count   <= r_count + 1'b1;
            if (r_count == C_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Desc     : Clocked ADD/MUL/AND/MAC datapath with valid/ready handshakes and a
//            persistent accumulator.
// Config   : define SEQ_ALU_MAC_SAT_EN for a saturating MAC (default wraps).
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result
);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_result;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_sum;
    logic [ACC_W-1:0]   w_mac_next;

    assign w_accept = in_valid && (r_state == IDLE);
    // MUL and MAC are the two encodings with op[0] set.
    assign w_start  = w_accept && op[0];
    assign w_sum    = {1'b0, a} + {1'b0, b};

`ifdef SEQ_ALU_MAC_SAT_EN
    logic [ACC_W:0] w_mac_sum;
    assign w_mac_sum  = {1'b0, r_acc} + (ACC_W+1)'(w_product);
    assign w_mac_next = w_mac_sum[ACC_W] ? {ACC_W{1'b1}} : w_mac_sum[ACC_W-1:0];
`else
    assign w_mac_next = r_acc + ACC_W'(w_product);
`endif

    seq_alu_mul_core #(
        .WIDTH   (WIDTH)
    ) u_mul_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_acc       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A same-cycle MAC accept sees the cleared value later in MULT.
                    if (acc_clr) begin
                        r_acc <= '0;
                    end
                    if (w_accept) begin
                        r_op <= op;
                        case (op)
                            OP_ADD: begin
                                r_result    <= ACC_W'(w_sum);
                                r_out_valid <= 1'b1;
                                r_state     <= OUT;
                            end
                            OP_AND: begin
                                r_result    <= ACC_W'(a & b);
                                r_out_valid <= 1'b1;
                                r_state     <= OUT;
                            end
                            default: begin
                                r_state <= MULT;
                            end
                        endcase
                    end
                end
                MULT: begin
                    if (w_mul_done) begin
                        if (r_op == OP_MAC) begin
                            r_acc    <= w_mac_next;
                            r_result <= w_mac_next;
                        end else begin
                            r_result <= ACC_W'(w_product);
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module   : tb_seq_alu
// Desc     : Scoreboard bench for seq_alu: directed and random ops versus an
//            arithmetic reference model; honours SEQ_ALU_MAC_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int     WIDTH   = 8;
    localparam int     ACC_W   = 20;
    localparam longint ACC_MAX = (64'sd1 << ACC_W) - 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             acc_clr   = 1'b0;
    logic             out_ready = 1'b1;
    logic [1:0]       op        = 2'b00;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] result;

    int               n_vec = 0;
    int               n_err = 0;
    logic [ACC_W-1:0] exp_q[$];
    longint           model_acc = 0;
    bit               mon_hold = 1'b0;
    logic [ACC_W-1:0] mon_prev = '0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH     (WIDTH),
        .ACC_W     (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference behaviour: plain integer arithmetic on the operation rules.
    function automatic logic [ACC_W-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y, input bit clr);
        longint xa = longint'(x);
        longint ya = longint'(y);
        if (clr) model_acc = 0;
        case (o)
            2'b00:   return ACC_W'(xa + ya);
            2'b01:   return ACC_W'(xa * ya);
            2'b10:   return ACC_W'(xa & ya);
            default: begin
                model_acc = model_acc + xa * ya;
`ifdef SEQ_ALU_MAC_SAT_EN
                if (model_acc > ACC_MAX) model_acc = ACC_MAX;
`else
                model_acc = model_acc % (ACC_MAX + 1);
`endif
                return ACC_W'(model_acc);
            end
        endcase
    endfunction

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_hold = 1'b0;
        end else begin
            if (out_valid && mon_hold) check("hold_stable", result, mon_prev);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got 0x%0h expected none", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
                mon_hold = 1'b0;
            end else begin
                mon_hold = out_valid;
                mon_prev = result;
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input bit clr, input int bp);
        int lat;
        int cyc;
        lat = (o == 2'b01 || o == 2'b11) ? WIDTH + 1 : 1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_idle", in_ready, 1);
        exp_q.push_back(model(o, x, y, clr));
        out_ready = (bp == 0);
        op = o; a = x; b = y; acc_clr = clr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        op = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
        cyc = 0;
        while (!out_valid && cyc < lat + 4) begin
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc + 1, lat);
        for (int i = 0; i < bp; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));
            acc_clr  = 1'($urandom_range(0, 1));
            op = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_released", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(2'b00, 8'hFF, 8'h01, 1'b0, 0);
        do_op(2'b10, 8'hA5, 8'h3C, 1'b0, 0);
        do_op(2'b01, 8'hFF, 8'hFF, 1'b0, 0);
        do_op(2'b11, 8'd3, 8'd4, 1'b1, 0);
        do_op(2'b11, 8'd5, 8'd6, 1'b0, 0);
        do_op(2'b00, 8'd1, 8'd1, 1'b0, 0);
        do_op(2'b11, 8'd1, 8'd1, 1'b0, 0);
        do_op(2'b00, 8'd7, 8'd8, 1'b0, 5);

        // Abort a multiply mid-flight; the accumulator (43 here) must be cleared.
        op = 2'b01; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mult_no_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_in_ready", in_ready, 1);
        model_acc = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(2'b01, 8'd2, 8'd3, 1'b0, 0);
        do_op(2'b11, 8'd2, 8'd2, 1'b0, 0);

        for (int i = 0; i < 17; i++) do_op(2'b11, 8'hFF, 8'hFF, (i == 0), 0);

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
